// File: rtl/conv_encoder_if.sv
// Streaming handshake bundle between the scrambler, the convolutional encoder
// and the interleaver.
interface conv_encoder_if;
  logic       iStart;
  logic [1:0] iRate;
  logic       iValid;
  logic       iData;
  logic       oReady;
  logic       oValid;
  logic       oData;
  logic       iReady;

  modport master (output iStart, iRate, iValid, iData, iReady,
                  input  oReady, oValid, oData);
  modport slave  (input  iStart, iRate, iValid, iData, iReady,
                  output oReady, oValid, oData);
endinterface

// File: rtl/conv_encoder.sv
// K=7 convolutional encoder with rate 1/2, 2/3 and 3/4 puncturing and a
// 2-entry serial output buffer.
module conv_encoder #(
  parameter logic [6:0] G0 = 7'o133,
  parameter logic [6:0] G1 = 7'o171
) (
  input logic           iClk,
  input logic           iRst,
  conv_encoder_if.slave bus
);

  typedef enum logic [1:0] {
    RATE_1_2 = 2'd0,
    RATE_2_3 = 2'd1,
    RATE_3_4 = 2'd2
  } rate_e;

  // s_q[5] is s1 (newest bit), s_q[0] is s6
  logic [5:0] s_q, s_d;
  logic [1:0] phase_q, phase_d;
  rate_e      rate_q, rate_d;
  logic [1:0] keep_q, keep_d;
  logic       a_q, b_q;

  logic [6:0] win;
  logic [1:0] mask;
  logic [1:0] phase_max;
  logic       one_left;
  logic       accept;
  logic       pop;

  assign win      = {bus.iData, s_q};
  assign one_left = keep_q[1] ^ keep_q[0];

  assign bus.oValid = |keep_q;
  assign bus.oData  = keep_q[1] ? a_q : (keep_q[0] & b_q);
  assign bus.oReady = !iRst && !bus.iStart &&
                      ((keep_q == 2'b00) || (one_left && bus.iReady));

  assign accept = bus.iValid && bus.oReady;
  assign pop    = bus.oValid && bus.iReady;

  // keep[1] = A, keep[0] = B
  always_comb begin
    mask      = 2'b11;
    phase_max = 2'd0;
    case (rate_q)
      RATE_2_3: begin
        phase_max = 2'd1;
        if (phase_q == 2'd1) mask = 2'b10;
      end
      RATE_3_4: begin
        phase_max = 2'd2;
        if (phase_q == 2'd1) mask = 2'b10;
        else if (phase_q == 2'd2) mask = 2'b01;
      end
      default: begin
        mask      = 2'b11;
        phase_max = 2'd0;
      end
    endcase
  end

  always_comb begin
    s_d     = s_q;
    phase_d = phase_q;
    rate_d  = rate_q;
    keep_d  = keep_q;
    if (bus.iStart) begin
      s_d     = '0;
      phase_d = 2'd0;
      keep_d  = 2'b00;
      rate_d  = (bus.iRate == 2'b11) ? RATE_1_2 : rate_e'(bus.iRate);
    end else begin
      if (pop) keep_d = keep_q[1] ? {1'b0, keep_q[0]} : 2'b00;
      // a new symbol only arrives once the old one is gone or leaving now
      if (accept) begin
        s_d     = {bus.iData, s_q[5:1]};
        keep_d  = mask;
        phase_d = (phase_q >= phase_max) ? 2'd0 : phase_q + 2'd1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      s_q     <= '0;
      phase_q <= 2'd0;
      rate_q  <= RATE_1_2;
      keep_q  <= 2'b00;
    end else begin
      s_q     <= s_d;
      phase_q <= phase_d;
      rate_q  <= rate_d;
      keep_q  <= keep_d;
    end
  end

  always_ff @(posedge iClk) begin
    if (accept) begin
      a_q <= ^(win & G0);
      b_q <= ^(win & G1);
    end
  end

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: golden vector table, hand-written
// corner sequences and a reference-model scoreboard on the serial output.
module tb_conv_encoder;

  logic iClk = 1'b0;
  logic iRst = 1'b1;

  conv_encoder_if ifc ();

  conv_encoder dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (ifc)
  );

  always #5 iClk = ~iClk;

  int   checks   = 0;
  int   failures = 0;
  int   beats    = 0;
  int   cyc      = 0;
  bit   exp_q[$];
  bit   use_model = 1'b0;
  bit   rnd_rdy   = 1'b0;
  bit   man_rdy   = 1'b1;
  bit   rnd_bit   = 1'b1;
  logic e_bit;

  assign ifc.iReady = rnd_rdy ? rnd_bit : man_rdy;

  always @(posedge iClk) begin
    cyc = cyc + 1;
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  typedef struct {
    logic [1:0]  rate;
    int          nin;
    logic [15:0] din;
    int          nout;
    logic [15:0] dout;
  } vec_t;

  localparam int NV = 7;
  vec_t tbl [NV];

  // independent reference model, written from the default-polynomial equations
  bit m_s [1:6];
  int m_phase;
  int m_rate;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(input int r);
    for (int i = 1; i <= 6; i++) m_s[i] = 1'b0;
    m_phase = 0;
    m_rate  = (r == 3) ? 0 : r;
  endtask

  task automatic model_push(input bit d);
    bit a, b, ka, kb;
    a  = d ^ m_s[2] ^ m_s[3] ^ m_s[5] ^ m_s[6];
    b  = d ^ m_s[1] ^ m_s[2] ^ m_s[3] ^ m_s[6];
    ka = 1'b1;
    kb = 1'b1;
    if (m_rate == 1 && m_phase == 1) kb = 1'b0;
    if (m_rate == 2 && m_phase == 1) kb = 1'b0;
    if (m_rate == 2 && m_phase == 2) ka = 1'b0;
    if (ka) exp_q.push_back(a);
    if (kb) exp_q.push_back(b);
    for (int i = 6; i > 1; i--) m_s[i] = m_s[i-1];
    m_s[1]  = d;
    m_phase = (m_phase + 1) % (m_rate + 1);
  endtask

  always @(negedge iClk) begin
    if (!iRst && ifc.oValid && ifc.iReady) begin
      beats = beats + 1;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bit: got oData=%0b with no bit expected (t=%0t)", ifc.oData, $time);
      end else begin
        e_bit = exp_q.pop_front();
        chk("oData", {31'd0, ifc.oData}, {31'd0, e_bit});
      end
    end
  end

  // all tasks below start and end at posedge+1
  task automatic start_pkt(input logic [1:0] r, input bit val_in_start);
    ifc.iStart = 1'b1;
    ifc.iRate  = r;
    ifc.iValid = val_in_start;
    ifc.iData  = 1'b1;
    @(negedge iClk);
    chk("oReady_in_start", {31'd0, ifc.oReady}, 32'd0);
    @(posedge iClk);
    #1;
    ifc.iStart = 1'b0;
    ifc.iValid = 1'b0;
    ifc.iRate  = ~r;
    model_reset(r);
  endtask

  task automatic send_bit(input bit b);
    bit got;
    got        = 1'b0;
    ifc.iValid = 1'b1;
    ifc.iData  = b;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge iClk);
      if (ifc.oReady) begin
        got = 1'b1;
        if (use_model) model_push(b);
      end
      @(posedge iClk);
      #1;
    end
    ifc.iValid = 1'b0;
    chk("accept_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge iClk);
      if (exp_q.size() == 0 && !ifc.oValid) done = 1'b1;
    end
    chk(name, {31'd0, done}, 32'd1);
    @(posedge iClk);
    #1;
  endtask

  task automatic push_golden_half();
    logic [13:0] g;
    g = 14'b11011111001011;
    for (int j = 13; j >= 0; j--) exp_q.push_back(g[j]);
  endtask

  task automatic push_golden_34();
    logic [7:0] g;
    g = 8'b11011100;
    for (int j = 7; j >= 0; j--) exp_q.push_back(g[j]);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic snap_v, snap_d;
    int   c0;

    tbl[0] = '{2'b00, 7, 16'b1000000,  14, 16'b11011111001011};
    tbl[1] = '{2'b10, 6, 16'b100000,    8, 16'b11011100};
    tbl[2] = '{2'b01, 6, 16'b100000,    9, 16'b110111001};
    tbl[3] = '{2'b11, 7, 16'b1000000,  14, 16'b11011111001011};
    tbl[4] = '{2'b00, 3, 16'b111,       6, 16'b111001};
    tbl[5] = '{2'b10, 3, 16'b111,       4, 16'b1111};
    tbl[6] = '{2'b01, 3, 16'b110,       5, 16'b11110};

    ifc.iStart = 1'b0;
    ifc.iRate  = 2'b00;
    ifc.iValid = 1'b0;
    ifc.iData  = 1'b0;
    iRst       = 1'b1;

    repeat (2) @(posedge iClk);
    #1;
    chk("rst_oValid", {31'd0, ifc.oValid}, 32'd0);
    chk("rst_oReady", {31'd0, ifc.oReady}, 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    chk("post_rst_oReady", {31'd0, ifc.oReady}, 32'd1);
    chk("post_rst_oValid", {31'd0, ifc.oValid}, 32'd0);
    chk("post_rst_oData",  {31'd0, ifc.oData},  32'd0);

    // golden vector table
    for (int t = 0; t < NV; t++) begin
      start_pkt(tbl[t].rate, 1'b0);
      for (int j = tbl[t].nout - 1; j >= 0; j--) exp_q.push_back(tbl[t].dout[j]);
      beats = 0;
      for (int i = tbl[t].nin - 1; i >= 0; i--) send_bit(tbl[t].din[i]);
      drain("drain_vec");
      chk("beats_vec", beats, tbl[t].nout);
    end

    // backpressure mid-stream
    start_pkt(2'b00, 1'b0);
    push_golden_half();
    beats = 0;
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    man_rdy    = 1'b0;
    ifc.iValid = 1'b1;
    ifc.iData  = 1'b1;
    @(negedge iClk);
    snap_v = ifc.oValid;
    snap_d = ifc.oData;
    chk("bp_valid", {31'd0, snap_v}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge iClk);
      chk("bp_valid_frozen", {31'd0, ifc.oValid}, {31'd0, snap_v});
      chk("bp_data_frozen",  {31'd0, ifc.oData},  {31'd0, snap_d});
      chk("bp_oReady",       {31'd0, ifc.oReady}, 32'd0);
    end
    @(posedge iClk);
    #1;
    ifc.iValid = 1'b0;
    man_rdy    = 1'b1;
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    drain("drain_bp");
    chk("beats_bp", beats, 14);

    // iStart mid-packet flushes pending bits and switches to rate 3/4
    start_pkt(2'b00, 1'b0);
    man_rdy = 1'b0;
    send_bit(1'b1);
    @(negedge iClk);
    chk("flush_pre_valid", {31'd0, ifc.oValid}, 32'd1);
    @(posedge iClk);
    #1;
    start_pkt(2'b10, 1'b1);
    chk("flush_valid", {31'd0, ifc.oValid}, 32'd0);
    man_rdy = 1'b1;
    push_golden_34();
    beats = 0;
    send_bit(1'b1);
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    drain("drain_flush");
    chk("beats_flush", beats, 8);

    // asynchronous reset between edges mid-stream
    start_pkt(2'b10, 1'b0);
    man_rdy = 1'b0;
    send_bit(1'b1);
    @(negedge iClk);
    chk("arst_pre_valid", {31'd0, ifc.oValid}, 32'd1);
    #2;
    iRst = 1'b1;
    #1;
    chk("arst_oValid", {31'd0, ifc.oValid}, 32'd0);
    chk("arst_oReady", {31'd0, ifc.oReady}, 32'd0);
    @(posedge iClk);
    #3;
    iRst = 1'b0;
    @(posedge iClk);
    #1;
    chk("arst_rel_oReady", {31'd0, ifc.oReady}, 32'd1);
    chk("arst_rel_oValid", {31'd0, ifc.oValid}, 32'd0);
    chk("arst_rel_oData",  {31'd0, ifc.oData},  32'd0);
    man_rdy = 1'b1;
    push_golden_half();
    beats = 0;
    send_bit(1'b1);
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    drain("drain_arst");
    chk("beats_arst", beats, 14);

    // output counts and sustained throughput with the reference model
    use_model = 1'b1;
    start_pkt(2'b01, 1'b0);
    beats = 0;
    for (int i = 0; i < 48; i++) send_bit(1'($urandom_range(0, 1)));
    drain("drain_cnt23");
    chk("beats_rate23", beats, 72);

    start_pkt(2'b10, 1'b0);
    beats = 0;
    c0    = cyc;
    for (int i = 0; i < 54; i++) send_bit(1'($urandom_range(0, 1)));
    drain("drain_cnt34");
    chk("beats_rate34", beats, 72);
    chk("no_bubbles_34", {31'd0, ((cyc - c0) <= 80)}, 32'd1);

    // random data under random downstream backpressure, every rate code
    rnd_rdy = 1'b1;
    for (int r = 0; r < 4; r++) begin
      start_pkt(2'(r), 1'b0);
      for (int i = 0; i < 30; i++) send_bit(1'($urandom_range(0, 1)));
      drain("drain_rnd");
    end
    rnd_rdy = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_encoder.md
CONV_ENCODER -- requirements
Module: conv_encoder

Interface
- REQ-001 SHALL have parameter G0, default 7'o133, generator polynomial for coded bit A.
- REQ-002 SHALL have parameter G1, default 7'o171, generator polynomial for coded bit B.
- REQ-003 SHALL have port iClk, input, 1, the single clock; all state updates on the rising edge.
- REQ-004 SHALL have port iRst, input, 1, asynchronous active-high reset.
- REQ-005 SHALL have port iStart, input, 1, single-cycle packet start; clears encoder state and latches iRate.
- REQ-006 SHALL have port iRate, input, 2, code rate: 00 = 1/2, 01 = 2/3, 10 = 3/4, 11 = treated as 1/2.
- REQ-007 SHALL have port iValid, input, 1, upstream (scrambler-side) data valid.
- REQ-008 SHALL have port iData, input, 1, scrambled data bit.
- REQ-009 SHALL have port oReady, output, 1, encoder can accept iData this cycle.
- REQ-010 SHALL have port oValid, output, 1, oData holds a valid coded bit.
- REQ-011 SHALL have port oData, output, 1, serial punctured coded bit.
- REQ-012 SHALL have port iReady, input, 1, downstream (interleaver) accepts oData this cycle.

Function
- REQ-013 SHALL keep a 6-bit shift register s[1:6], with s1 the most recent accepted bit.
- REQ-014 SHALL compute A as the XOR of the G0 taps over (d, s1..s6), with the MSB of G0 applied to d; with defaults, A = d^s2^s3^s5^s6.
- REQ-015 SHALL compute B the same way from G1; with defaults, B = d^s1^s2^s3^s6.
- REQ-016 SHALL accept an input bit only on a cycle where iValid and oReady are both high.
- REQ-017 On acceptance, SHALL shift d into s1 and load A and B plus a keep-mask into a 2-entry output buffer.
- REQ-018 SHALL keep a puncture phase counter: 0 only for rate 1/2; 0..1 for rate 2/3; 0..2 for rate 3/4.
- REQ-019 The phase counter SHALL advance once per accepted bit and wrap to 0 after its maximum value.
- REQ-020 Keep-mask for rate 1/2: A and B kept in every phase.
- REQ-021 Keep-mask for rate 2/3: phase 0 keeps A and B; phase 1 keeps A only.
- REQ-022 Keep-mask for rate 3/4: phase 0 keeps A and B; phase 1 keeps A only; phase 2 keeps B only.
- REQ-023 SHALL emit kept bits in A-then-B order; punctured bits SHALL never appear on oData and SHALL cost no cycle.
- REQ-024 Latency: the first kept bit SHALL appear on oValid/oData in the cycle after acceptance.
- REQ-025 A bit SHALL leave the buffer only when oValid and iReady are both high.
- REQ-026 While oValid is high and iReady is low, oValid and oData SHALL stay stable.
- REQ-027 oReady SHALL be combinational: high when the buffer is empty, or when exactly one kept bit remains and iReady is high.
- REQ-028 The oReady rule gives back-to-back operation without bubbles: rate 1/2 sustains one input per 2 cycles, and single-bit phases sustain one input per cycle.
- REQ-029 iStart SHALL take priority over everything else: clear s, set phase to 0, flush the buffer, and latch iRate.
- REQ-030 oReady SHALL be low during the iStart cycle, and any iValid in that cycle SHALL be ignored.
- REQ-031 iRate SHALL be sampled only when iStart is high; changes at other times SHALL have no effect.
- REQ-032 Tail and pad bits SHALL get no special handling; upstream supplies the zero bits.

Reset
- REQ-033 While iRst is high, s, phase, buffer and latched rate (rate 1/2) SHALL be cleared asynchronously, and oValid and oReady SHALL be held at 0.
- REQ-034 After iRst is released: oValid = 0, oData = 0, and oReady = 1 from the first clock edge.
- REQ-035 Reset mid-packet SHALL discard all pending bits, with no further oValid until new input is accepted.

Verification
- REQ-036 Rate 1/2 impulse: iStart, then inputs 1,0,0,0,0,0,0 with iReady=1 -> oData sequence 11 01 11 11 00 10 11 (14 bits).
- REQ-037 Rate 3/4 impulse: iStart, then inputs 1,0,0,0,0,0 -> oData 1101 1100 (8 bits).
- REQ-038 Output count: rate 2/3 with 48 inputs -> exactly 72 oValid&iReady beats; rate 3/4 with 54 inputs -> 72 beats.
- REQ-039 Backpressure: hold iReady=0 for 5 cycles mid-stream -> oValid/oData are frozen, oReady=0, and the final sequence matches the REQ-036 golden output.
- REQ-040 iStart mid-packet with iRate=10 -> buffer is flushed, no stale bits appear, and the next impulse reproduces the REQ-037 output.
- REQ-041 Async iRst pulse between clock edges mid-stream -> oValid drops immediately, and the next rate 1/2 impulse after release reproduces the REQ-036 output.
